// File: rtl/inst_enc_pkg.sv
// ----------------------------------------------------------------------------
// inst_enc_pkg : opcode/funct constants, error/state enums and the field packer
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package inst_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_RANGE  = 2'b01,
    ERR_ALIGN  = 2'b10,
    ERR_OPCODE = 2'b11
  } err_e;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    err_e        err;
  } enc_result_t;

  function automatic enc_result_t encode(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    enc_result_t r;
    logic        fits12;
    logic        fits13;
    logic        fits_sh;
    // An N-bit signed value fits when every bit above the sign bit matches it
    fits12  = (&imm[31:11]) | ~(|imm[31:11]);
    fits13  = (&imm[31:12]) | ~(|imm[31:12]);
    fits_sh = ~(|imm[31:5]);
    r.inst  = '0;
    r.err   = ERR_NONE;
    case (op)
      OP_R: r.inst = {f7, rs2, rs1, f3, rd, op};
      OP_LOAD: begin
        r.inst = {imm[11:0], rs1, f3, rd, op};
        if (!fits12) r.err = ERR_RANGE;
      end
      OP_IMM: begin
        if (f3 == F3_SLL) begin
          r.inst = {F7_ZERO, imm[4:0], rs1, f3, rd, op};
          if (!fits_sh) r.err = ERR_RANGE;
        end else if (f3 == F3_SR) begin
          r.inst = {f7, imm[4:0], rs1, f3, rd, op};
          if (!fits_sh || (f7 != F7_ZERO && f7 != F7_SRA)) r.err = ERR_RANGE;
        end else begin
          r.inst = {imm[11:0], rs1, f3, rd, op};
          if (!fits12) r.err = ERR_RANGE;
        end
      end
      OP_STORE: begin
        r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        if (!fits12) r.err = ERR_RANGE;
      end
      OP_BRANCH: begin
        r.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        if (imm[0])       r.err = ERR_ALIGN;
        else if (!fits13) r.err = ERR_RANGE;
      end
      default: r.err = ERR_OPCODE;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_fifo2.sv
// ----------------------------------------------------------------------------
// enc_fifo2 : two-entry FIFO; push while full and pop while empty are ignored
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module enc_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// ----------------------------------------------------------------------------
// inst_encoder : packs decoded RISC-V fields into 32-bit words with range
//                checking, a 2-deep output FIFO and sequential byte addresses
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  input  logic              err_clear,
  output logic [15:0]       enc_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_valid_q, err_valid_d;
  err_e              err_code_q, err_code_d;

  enc_result_t enc;
  logic        fifo_full, fifo_empty;
  logic        accept, push, pop, enc_err;

  assign enc     = encode(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
  assign enc_err = (enc.err != ERR_NONE);

  assign in_ready  = (state_q == RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !enc_err;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  enc_fifo2 #(
    .W (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (enc.inst),
    .pop       (pop),
    .rd_data   (out_inst),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The address belongs to the head, so it only moves when the head leaves
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_valid_d = accept && enc_err;
    err_code_d  = (accept && enc_err) ? enc.err : ERR_NONE;
    if (pop) begin
      addr_d = addr_q + ADDR_W'(4);
    end
    if (push && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
    case (state_q)
      RUN: begin
        if (accept && enc_err && STOP_ON_ERR) state_d = HALT;
      end
      HALT: begin
        if (err_clear) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      addr_q      <= '0;
      count_q     <= 16'd0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_addr  = addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign enc_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ----------------------------------------------------------------------------
// tb_inst_encoder : directed plus random stimulus against a queue-based model
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_inst_encoder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              err_clear;
  logic [15:0]       enc_count;

  always #5 clk = ~clk;

  inst_encoder #(
    .ADDR_W      (ADDR_W),
    .STOP_ON_ERR (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_clear (err_clear),
    .enc_count (enc_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: queued words, head address, push count, halt flag, error pulse
  logic [31:0]       mq[$];
  logic [ADDR_W-1:0] m_addr;
  int                m_cnt;
  bit                m_halt;
  bit                m_errv;
  int                m_code;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_enc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, output logic [31:0] w);
    int s;
    s = $signed(imm);
    w = 32'd0;
    if (op == 7'h33) begin
      w = {f7, rs2, rs1, f3, rd, op};
      return 0;
    end
    if (op == 7'h03 || (op == 7'h13 && f3 != 3'd1 && f3 != 3'd5)) begin
      w = {imm[11:0], rs1, f3, rd, op};
      return (s < -2048 || s > 2047) ? 1 : 0;
    end
    if (op == 7'h13) begin
      w = {(f3 == 3'd5) ? f7 : 7'd0, imm[4:0], rs1, f3, rd, op};
      if (s < 0 || s > 31) return 1;
      if (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'h20) return 1;
      return 0;
    end
    if (op == 7'h23) begin
      w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      return (s < -2048 || s > 2047) ? 1 : 0;
    end
    if (op == 7'h63) begin
      w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      if (s % 2 != 0) return 2;
      return (s < -4096 || s > 4094) ? 1 : 0;
    end
    return 3;
  endfunction

  task automatic check_all();
    check_val("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) check_val("out_inst", out_inst, mq[0]);
    check_val("out_addr", out_addr, m_addr);
    check_val("in_ready", in_ready, !m_halt && mq.size() < 2);
    check_val("err_valid", err_valid, m_errv);
    if (m_errv) check_val("err_code", err_code, m_code);
    check_val("enc_count", enc_count, m_cnt[15:0]);
  endtask

  // Advance the model for the inputs now applied, clock once, compare at negedge
  task automatic tick();
    logic [31:0] w;
    int          code;
    bit          acc, pop;
    if (!rst_n) begin
      mq.delete();
      m_addr = '0;
      m_cnt  = 0;
      m_halt = 0;
      m_errv = 0;
      m_code = 0;
    end else begin
      acc  = in_valid && !m_halt && mq.size() < 2;
      pop  = (mq.size() > 0) && out_ready;
      code = ref_enc(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, w);
      if (pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + ADDR_W'(4);
      end
      if (acc && code == 0) begin
        mq.push_back(w);
        if (m_cnt < 65535) m_cnt++;
      end
      m_errv = acc && code != 0;
      m_code = m_errv ? code : 0;
      if (m_errv) m_halt = 1;
      else if (m_halt && err_clear) m_halt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input bit v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    in_valid  = v;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic recover();
    in_valid  = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  int bnd[14] = '{-4097, -4096, -4094, -2049, -2048, -1, 0, 31, 32, 2047, 2048, 4094, 4095, 4096};

  initial begin
    logic [6:0]  op;
    logic [31:0] imm;
    logic [6:0]  f7;
    rst_n = 1'b0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    set_in(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    tick();
    check_val("rst_out_inst", out_inst, 32'd0);
    check_val("rst_err_code", err_code, 2'd0);
    rst_n = 1'b1;

    out_ready = 1'b1;
    set_in(1'b1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    check_val("addi_m1", out_inst, 32'hFFF0_0093);
    check_val("addi_addr", out_addr, 0);
    check_val("addi_cnt", enc_count, 16'd1);
    set_in(1'b1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    check_val("sw_inst", out_inst, 32'h0020_A423);
    set_in(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    tick();
    check_val("beq_inst", out_inst, 32'hFE20_8EE3);
    set_in(1'b1, 7'h13, 3'd5, 7'h20, 5'd3, 5'd1, 5'd0, 32'd4);
    tick();
    check_val("srai_inst", out_inst, 32'h4040_D193);

    set_in(1'b1, 7'h13, 3'd1, 7'd0, 5'd3, 5'd1, 5'd0, 32'd32);
    tick();
    check_val("slli32_code", err_code, 2'd1);
    recover();

    set_in(1'b1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    check_val("addi2048_errv", err_valid, 1'b1);
    check_val("addi2048_code", err_code, 2'd1);
    in_valid = 1'b0;
    tick();
    check_val("halt_pulse_end", err_valid, 1'b0);
    check_val("halt_ready", in_ready, 1'b0);
    recover();
    check_val("clear_ready", in_ready, 1'b1);

    set_in(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    tick();
    check_val("beq_odd_code", err_code, 2'd2);
    recover();
    set_in(1'b1, 7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    check_val("bad_op_code", err_code, 2'd3);
    recover();

    // Backpressure: three words offered with the consumer stalled
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, 7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
      tick();
      if (k == 2) check_val("bp_full_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    // Reset with two entries buffered
    out_ready = 1'b0;
    set_in(1'b1, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check_val("mid_rst_valid", out_valid, 1'b0);
    check_val("mid_rst_addr", out_addr, 0);
    check_val("mid_rst_cnt", enc_count, 16'd0);
    check_val("mid_rst_ready", in_ready, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 7'h33;
        2:       op = 7'h03;
        3, 4, 9: op = 7'h13;
        5:       op = 7'h23;
        6, 7:    op = 7'h63;
        default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       imm = 32'($urandom_range(0, 63)) - 32'd32;
        1:       imm = 32'(bnd[$urandom_range(0, 13)]);
        2:       imm = $urandom;
        3:       imm = 32'($urandom_range(0, 40));
        default: imm = 32'($urandom_range(0, 8400)) - 32'd4200;
      endcase
      case ($urandom_range(0, 2))
        0:       f7 = 7'd0;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      set_in($urandom_range(0, 3) != 0, op, 3'($urandom), f7,
             5'($urandom), 5'($urandom), 5'($urandom), imm);
      out_ready = $urandom_range(0, 2) != 0;
      err_clear = $urandom_range(0, 3) == 0;
      rst_n     = (i != 700);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RISC-V instruction encoder. It is the inverse of the immediate generator: it accepts decoded fields (opcode, funct3, funct7, registers, 32-bit immediate) and packs them into a 32-bit instruction word.
- It range-checks the immediate for the target format and buffers results in a 2-entry output FIFO.
- It tags each emitted word with a sequential instruction-memory address.
- It feeds the instruction-memory loader and the self-test program generator.

Parameters:
- ADDR_W, 8, width of the out_addr byte-address counter.
- STOP_ON_ERR, 1, when 1 the block halts after an encode error until err_clear.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block accepts fields this cycle.
- in_opcode  in  7  opcode.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; used for R-type and SRLI/SRAI only.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate as a 32-bit two's-complement value.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_inst.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  error cause; valid while err_valid=1.
- err_clear  in  1  leave HALT state.
- enc_count  out  16  number of words pushed, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied; out_valid=0; out_inst=0; out_addr=0.
  - err_valid=0; err_code=0; enc_count=0; state=RUN.
  - Applies mid-transfer as well; in-flight entries are discarded.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==RUN) && FIFO not full. A pop in the same cycle does not raise in_ready.
- Latency: the word is encoded combinationally on accept and pushed the same edge, so out_valid is 1 the following cycle.
- Output: out_inst and out_addr show the FIFO head and stay stable while out_valid && !out_ready.
- Encoding, by opcode:
  - 0110011 (R-type): {funct7, rs2, rs1, f3, rd, op}.
  - 0000011 (load) and 0010011 (op-imm) with f3 not in {001, 101}: I-type, {imm[11:0], rs1, f3, rd, op}. Legal range -2048..2047.
  - 0010011 with f3=001: {0000000, imm[4:0], rs1, f3, rd, op}.
  - 0010011 with f3=101: {funct7, imm[4:0], rs1, f3, rd, op}.
  - Shift rules: imm must be 0..31; for f3=101, funct7 must be 0000000 or 0100000.
  - 0100011 (S-type): {imm[11:5], rs2, rs1, f3, imm[4:0], op}. Legal range -2048..2047.
  - 1100011 (B-type): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}. Legal range -4096..4094; imm[0] must be 0.
- Errors (checked in the accept cycle; the word is not pushed and enc_count is not incremented; err_valid pulses the next cycle):
  - 01: immediate out of range, or illegal shift funct7.
  - 10: B-type immediate odd.
  - 11: unsupported opcode.
  - If several apply, the priority is 11 > 10 > 01.
- State machine:
  - RUN: on error, go to HALT if STOP_ON_ERR=1; otherwise stay in RUN.
  - HALT: in_ready=0. The FIFO keeps draining to the consumer. err_clear=1 returns to RUN on the next edge.
  - err_clear in RUN has no effect.
- out_addr:
  - Advances by 4 on each pop (out_valid && out_ready).
  - Wraps modulo 2^ADDR_W; it is the address of the current head.
- enc_count: +1 per push; holds at 0xFFFF.
- Simultaneous events:
  - Push and pop in the same cycle with 1 entry: occupancy stays 1 and order is preserved.
  - Error and err_clear in the same cycle: the error wins and the state is HALT.

Decomposition:
- Package inst_enc_pkg holds:
  - opcode constants OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_R.
  - funct3 constants F3_SLL, F3_SR.
  - err_code enum ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_OPCODE.
  - state enum RUN, HALT.
- Sub-module enc_fifo2: 2-entry FIFO, 32+ADDR_W bits wide, synchronous active-low reset, full/empty flags. The address may be tracked at pop time instead of being stored per entry.

Test Plan:
- ADDI x1, x0, -1 (op 0010011, f3 000, rd 1, rs1 0, imm 0xFFFFFFFF) -> next cycle out_valid=1, out_inst=0xFFF00093, out_addr=0, enc_count=1.
- SW x2, 8(x1) (op 0100011, f3 010, rs1 1, rs2 2, imm 8), then BEQ x1, x2, -4 (op 1100011, f3 000, imm 0xFFFFFFFC), with out_ready=1 -> 0x0020A423 at addr 0, then 0xFE208EE3 at addr 4.
- SRAI x3, x1, 4 (f3 101, funct7 0100000, imm 4) -> 0x4040D193.
- SLLI with imm 32 -> err_code 01.
- ADDI with imm 2048, STOP_ON_ERR=1 -> no push; err_valid=1 for exactly one cycle with err_code 01; in_ready=0 until err_clear, then 1 next cycle.
- BEQ with imm 3 -> err_code 10.
- Opcode 1111111 -> err_code 11.
- out_ready=0, offer 3 valid words -> in_ready=0 after 2 accepted. Then out_ready=1 -> words in order at out_addr 0, 4, 8; third accepted when space appears.
- ADDR_W=4: 5 pops -> out_addr sequence 0, 4, 8, 12, 0.
- Reset mid-stream: rst_n=0 for 1 cycle with 2 entries buffered -> out_valid=0, out_addr=0, enc_count=0, in_ready=1 after release.
